// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM state encoding and operation codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used for operand magnitudes and for the final result sign fix.
// Latency: combinational.
// Backpressure: none.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    // Negate when requested; MIN maps onto itself, which the divider relies on for MIN / -1.
    always_comb begin
        res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;
    end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and restoring divide, one result bit per clock.
// Latency: WIDTH+1 cycles from accepted start to the one-cycle ready pulse; busy covers CALC and DONE.
// Backpressure: start is ignored while busy; annul aborts at once. Optional div_zero port: MULDIV_DIVZERO_FLAG_EN.
module iter_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q;
    logic               neg_lo_q;   // product / quotient needs negating
    logic               neg_hi_q;   // remainder needs negating (dividend was negative)
    logic [WIDTH-1:0]   opb_q;      // multiplicand magnitude (MUL) or divisor magnitude (DIV)
    logic [2*WIDTH-1:0] acc_q;      // MUL: {partial product, multiplier}; DIV: low half is dividend -> quotient
    logic [WIDTH:0]     rem_q;      // DIV partial remainder
    logic               ready_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic               div_zero_q;
`endif

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH+1:0]   add_a;
    logic [WIDTH+1:0]   add_b;
    logic [WIDTH+1:0]   add_s;
    logic               add_sub;
    logic               borrow;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH:0]     rem_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (a),
        .neg_i (sign & a[WIDTH-1]),
        .res_o (a_mag)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (b),
        .neg_i (sign & b[WIDTH-1]),
        .res_o (b_mag)
    );

    // One iteration through the shared adder/subtractor: add-or-skip for MUL, trial subtract for DIV.
    // The remainder's top bit is always 0 after a restore, so {rem_q, next dividend bit} is the shifted value.
    always_comb begin
        add_sub = 1'b0;
        add_a   = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
        add_b   = '0;
        if (op_q == OP_MUL) begin
            if (acc_q[0]) begin
                add_b = {2'b00, opb_q};
            end
        end else begin
            add_sub = 1'b1;
            add_a   = {rem_q, acc_q[WIDTH-1]};
            add_b   = {2'b00, opb_q};
        end
        add_s  = add_a + (add_b ^ {(WIDTH+2){add_sub}}) + {{(WIDTH+1){1'b0}}, add_sub};
        borrow = add_s[WIDTH+1];
        if (op_q == OP_MUL) begin
            acc_d = {add_s[WIDTH:0], acc_q[WIDTH-1:1]};
            rem_d = rem_q;
        end else begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~borrow};
            rem_d = borrow ? add_a[WIDTH:0] : add_s[WIDTH:0];
        end
    end

    muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val_i (acc_d),
        .neg_i (neg_lo_q),
        .res_o (prod_fix)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
        .val_i (acc_d[WIDTH-1:0]),
        .neg_i (neg_lo_q),
        .res_o (quo_fix)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .val_i (rem_d[WIDTH-1:0]),
        .neg_i (neg_hi_q),
        .res_o (rem_fix)
    );

    // Select the sign-fixed result that is written on the CALC->DONE edge.
    always_comb begin
        hi_d = (op_q == OP_DIV) ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d = (op_q == OP_DIV) ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // Control FSM with datapath registers; annul overrides everything except reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MUL;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            opb_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            ready_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else if (annul) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        state_q  <= CALC;
                        cnt_q    <= '0;
                        op_q     <= op_div;
                        neg_lo_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_q <= sign & a[WIDTH-1];
                        rem_q    <= '0;
                        if (op_div == OP_DIV) begin
                            opb_q <= b_mag;
                            acc_q <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opb_q <= a_mag;
                            acc_q <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q    <= DONE;
                        ready_q    <= 1'b1;
                        hi_q       <= hi_d;
                        lo_q       <= lo_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
                        div_zero_q <= (op_q == OP_DIV) && (opb_q == '0);
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign ready = ready_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    assign div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed bench for iter_muldiv_unit at WIDTH=32 plus a WIDTH=8 instance.
// Vectors carry hand-computed results; latency, busy span and ready pulse are checked per operation.
// Optional div_zero port is covered when MULDIV_DIVZERO_FLAG_EN is defined.
module tb_iter_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_div;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        busy;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic        div_zero;
    logic        s8_div_zero;
`endif

    logic        s8_start;
    logic        s8_op_div;
    logic        s8_sign;
    logic [7:0]  s8_a;
    logic [7:0]  s8_b;
    logic        s8_annul;
    logic        s8_busy;
    logic        s8_ready;
    logic [7:0]  s8_hi;
    logic [7:0]  s8_lo;

    int total;
    int bad;

    iter_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_div   (op_div),
        .sign     (sign),
        .a        (a),
        .b        (b),
        .annul    (annul),
        .busy     (busy),
        .ready    (ready),
        .hi       (hi),
        .lo       (lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
        ,
        .div_zero (div_zero)
`endif
    );

    iter_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (s8_start),
        .op_div   (s8_op_div),
        .sign     (s8_sign),
        .a        (s8_a),
        .b        (s8_b),
        .annul    (s8_annul),
        .busy     (s8_busy),
        .ready    (s8_ready),
        .hi       (s8_hi),
        .lo       (s8_lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
        ,
        .div_zero (s8_div_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Drives one start at the current negedge, scrambles inputs afterwards, waits for ready.
    task automatic run_op(input logic d, input logic s, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] h, output logic [31:0] l,
                          output int lat, output int bcnt, output logic [1:0] post);
        start  = 1'b1;
        op_div = d;
        sign   = s;
        a      = av;
        b      = bv;
        @(negedge clk);
        start  = 1'b0;
        op_div = ~d;
        sign   = ~s;
        a      = ~av;
        b      = ~bv;
        lat    = 1;
        bcnt   = 0;
        while (ready !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) bcnt++;
        h = hi;
        l = lo;
        @(negedge clk);
        post = {busy, ready};
    endtask

    typedef struct {
        string       name;
        logic        d;
        logic        s;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [31:0] h;
        logic [31:0] l;
        int          lat;
        int          bcnt;
        logic [1:0]  post;
        logic        seen_rdy;

        total = 0;
        bad   = 0;

        vt[0]  = '{"udiv_7_2",       1'b1, 1'b0, 32'd7,        32'd2,        32'd1,        32'd3};
        vt[1]  = '{"sdiv_m7_2",      1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[2]  = '{"sdiv_min_m1",    1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
        vt[3]  = '{"smul_m3_5",      1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[4]  = '{"umul_max_max",   1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[5]  = '{"udiv_5_0",       1'b1, 1'b0, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vt[6]  = '{"umul_2_3",       1'b0, 1'b0, 32'd2,        32'd3,        32'd0,        32'd6};
        vt[7]  = '{"udiv_100_7",     1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
        vt[8]  = '{"sdiv_7_m2",      1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vt[9]  = '{"smul_m1_m1",     1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
        vt[10] = '{"udiv_max_16",    1'b1, 1'b0, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
        vt[11] = '{"umul_shift",     1'b0, 1'b0, 32'h12345678, 32'h100,      32'h12,       32'h34567800};

        rst = 1'b1; start = 1'b0; op_div = 1'b0; sign = 1'b0; a = '0; b = '0; annul = 1'b0;
        s8_start = 1'b0; s8_op_div = 1'b0; s8_sign = 1'b0; s8_a = '0; s8_b = '0; s8_annul = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy",  {63'd0, busy},  64'd0);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_hi",    {32'd0, hi},    64'd0);
        chk("reset_lo",    {32'd0, lo},    64'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        chk("reset_div_zero", {63'd0, div_zero}, 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].d, vt[i].s, vt[i].av, vt[i].bv, h, l, lat, bcnt, post);
            chk({vt[i].name, "_hilo"},    {h, l}, {vt[i].eh, vt[i].el});
            chk({vt[i].name, "_latency"}, 64'(lat),  64'd33);
            chk({vt[i].name, "_busy"},    64'(bcnt), 64'd33);
            chk({vt[i].name, "_idle"},    {62'd0, post}, 64'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
            chk({vt[i].name, "_dz"}, {63'd0, div_zero}, {63'd0, (vt[i].d && vt[i].bv == 32'd0)});
`endif
        end

        // Annul 10 cycles into a divide: no ready, results held, then an immediate restart.
        start = 1'b1; op_div = 1'b1; sign = 1'b0; a = 32'd9; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        seen_rdy = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (ready === 1'b1) seen_rdy = 1'b1;
            @(negedge clk);
        end
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        if (ready === 1'b1) seen_rdy = 1'b1;
        chk("annul_busy",     {63'd0, busy}, 64'd0);
        chk("annul_no_ready", {63'd0, seen_rdy}, 64'd0);
        chk("annul_hilo_held", {hi, lo}, {vt[11].eh, vt[11].el});
        run_op(1'b1, 1'b0, 32'd9, 32'd4, h, l, lat, bcnt, post);
        chk("after_annul_hilo",    {h, l}, {32'd1, 32'd2});
        chk("after_annul_latency", 64'(lat), 64'd33);

        // annul beats a same-cycle start.
        start = 1'b1; annul = 1'b1; op_div = 1'b0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        chk("annul_beats_start", {63'd0, busy}, 64'd0);

        // start held high throughout with inputs changing mid-operation: only the first is taken.
        start = 1'b1; op_div = 1'b0; sign = 1'b0; a = 32'd11; b = 32'd13;
        lat = 0;
        seen_rdy = 1'b0;
        while (lat < 100 && !seen_rdy) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                op_div = 1'b1; a = 32'd1000; b = 32'd3;
            end
            if (ready === 1'b1) seen_rdy = 1'b1;
        end
        start = 1'b0;
        chk("held_start_latency", 64'(lat), 64'd33);
        chk("held_start_hilo", {hi, lo}, {32'd0, 32'd143});
        @(negedge clk);
        @(negedge clk);

        // Reset in the fifth CALC cycle with start still high clears every output.
        start = 1'b1; op_div = 1'b1; sign = 1'b0; a = 32'd77; b = 32'd5;
        for (int k = 0; k < 5; k++) @(negedge clk);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("mid_rst_busy",  {63'd0, busy},  64'd0);
        chk("mid_rst_ready", {63'd0, ready}, 64'd0);
        chk("mid_rst_hilo",  {hi, lo}, 64'd0);
        @(negedge clk);

        // WIDTH=8 instance: unsigned 0xFF * 0xFF with 9-cycle latency.
        s8_start = 1'b1; s8_op_div = 1'b0; s8_sign = 1'b0; s8_a = 8'hFF; s8_b = 8'hFF;
        @(negedge clk);
        s8_start = 1'b0; s8_a = 8'h00; s8_b = 8'h00;
        lat = 1;
        while (s8_ready !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_latency", 64'(lat), 64'd9);
        chk("w8_hilo", {48'd0, s8_hi, s8_lo}, {48'd0, 8'hFE, 8'h01});
        @(negedge clk);
        chk("w8_idle", {62'd0, s8_busy, s8_ready}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
